stats_seq_ctrl: RTL and testbench
=================================

# stats_seq_ctrl

Session sequencer for the switch/LED statistics datapath. It paces operator entry of a count N, N 8-bit samples and an operation code off a programmable tick. It then schedules one shared serial accumulator, a shared restoring divider and an iterative square-root unit to produce one of four results: sum, mean, sum of squares or standard deviation. It sits between the board switches/start button and the LED bank.

## Interface
- MAX_N, 10, sample buffer depth; N above this is clamped.
- TICK_DIV, 100000000, clock cycles between entry captures (benches use 4).
- clk  in  1  board clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  8  switch value captured on each entry tick.
- start  in  1  single-cycle pulse that begins a session; ignored while busy=1.
- led  out  8  echo of the last captured value during entry, result afterwards.
- busy  out  1  high from the accepted start until done.
- done  out  1  single-cycle pulse when led first shows the result.

## Operation
- States: IDLE, GET_N, GET_X, GET_OP, ACCUM, DIV1, DIV2, VAR, SQRT, FIN, SHOW.
- Reset (async, any state): state IDLE; led=0, busy=0, done=0; all counters, accumulators and the buffer index are 0.
- IDLE/SHOW, start=1: go to GET_N; tick counter=0; led=0; busy=1.
- Tick: fires when the counter reaches TICK_DIV-1, then the counter wraps to 0. The counter runs only in GET_N, GET_X and GET_OP.
- GET_N at tick:
  - sw=0: stay in GET_N and re-sample at the next tick.
  - sw>MAX_N: n=MAX_N.
  - Otherwise: n=sw.
  - led<=sw; go to GET_X with idx=0.
- GET_X at tick: buf[idx]<=sw; led<=sw; idx++. After n captures go to GET_OP.
- GET_OP at tick: op = sw if sw≤2, else 3. led is unchanged. Go to ACCUM.
- ACCUM: one buffer entry per cycle over n cycles.
  - sum (12 bits) += x.
  - sumsq (20 bits) += x*x.
  - No overflow is possible at MAX_N=10.
- After ACCUM, by op:
  - op0: res=sum, go to FIN.
  - op2: res=sumsq, go to FIN.
  - op1: DIV1 computes sum/n, res=quotient, go to FIN.
  - op3: DIV1 computes q1=sumsq/n. DIV2 computes m=sum/n. VAR computes v=q1-m*m (always ≥0, 16 bits). SQRT computes res=floor(sqrt(v)). Go to FIN.
- Divider: one shared restoring unit, 20-bit dividend, 4-bit divisor, one quotient bit per cycle, truncating. n is never 0.
- SQRT: bitwise non-restoring integer square root, one result bit per cycle, 8 cycles.
- FIN: led<=res[7:0] (truncated modulo 256); done=1 for this cycle; busy=0. Go to SHOW.
- SHOW: hold led until the next start.
- start while busy=1: ignored, with no effect on state or counters.

## Timing
- Reference cycle: the first tick is TICK_DIV cycles after the start edge. Let T be the cycle of the GET_OP tick.
- ACCUM occupies T+1..T+n.
- FIN and done by op:
  - op0 and op2: FIN/done at T+n+1.
  - op1: DIV1 at T+n+1..T+n+20; FIN at T+n+21.
  - op3: DIV1 at T+n+1..T+n+20, DIV2 at T+n+21..T+n+40, VAR at T+n+41, SQRT at T+n+42..T+n+49; FIN at T+n+50.
- led is registered; the new value is visible the cycle after the capturing edge.
- done is high for exactly one cycle; busy falls in the same cycle that done rises.
- Entry captures are spaced exactly TICK_DIV cycles apart. The sw=0 re-sample in GET_N costs one extra tick.

## Test plan
- TICK_DIV=4, N=8, samples 2,4,4,4,5,5,7,9, then each op in separate sessions:
  - op0 -> led=40.
  - op1 -> led=5.
  - op2 -> led=232.
  - op3 -> led=2 (q1=29, m=5, v=4).
  - Check done timing at T+9, T+29, T+9 and T+58 respectively.
- N=10, all samples 255:
  - op0 -> led=246 (2550 mod 256).
  - op1 -> led=255.
  - op2 -> led=0x0A (650250 mod 256).
  - op3 -> led=0.
- N entry: sw=0 at the first tick -> stays in GET_N, led=0, re-samples. Then sw=12 -> clamped, exactly 10 sample captures precede GET_OP.
- Op code sw=7 with samples 1,3 (N=2) -> treated as stddev: q1=5, m=2, v=1 -> led=1.
- Assert rst_n low during DIV1 -> led=0, busy=0 immediately (asynchronous). After release, a new start runs a clean session: N=1, sample 9, op0 -> led=9.
- Pulse start during ACCUM and during GET_X -> ignored; session result and timing are unchanged. A start in SHOW restarts and clears led to 0.

Source files
------------

// File: rtl/stats_seq_ctrl_if.sv
// stats_seq_ctrl_if: operator switches/start in, LED bank and status out.
interface stats_seq_ctrl_if;
  logic [7:0] sw;
  logic       start;
  logic [7:0] led;
  logic       busy;
  logic       done;
  modport master (output sw, start, input led, busy, done);
  modport slave (input sw, start, output led, busy, done);
endinterface

// File: rtl/stats_seq_ctrl.sv
// stats_seq_ctrl: paced entry of N, samples and op, then serial sum/mean/sumsq/stddev
// on one shared accumulator, restoring divider and non-restoring square root.
module stats_seq_ctrl #(
  parameter int MAX_N    = 10,
  parameter int TICK_DIV = 100000000
) (
  input logic            clk,
  input logic            rst_n,
  stats_seq_ctrl_if.slave io
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int IW = $clog2(MAX_N + 1);
  typedef enum logic [3:0] {IDLE, GET_N, GET_X, GET_OP, ACCUM, DIV1, DIV2, VAR, SQRT, FIN, SHOW} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] n, idx, rem, rem_n;
  logic [IW:0] trial;
  logic [7:0] mem [MAX_N];
  logic [1:0] op;
  logic [11:0] sum, sr, sr_sh, sr_n;
  logic [19:0] sumsq, dq, dsrc, dq_n;
  logic [15:0] q1, vs, sq, mm;
  logic [7:0] m, res, rt, rt_n, led, x;
  logic [4:0] dcnt;
  logic [2:0] scnt;
  logic run, tick, ge, last_div, busy, done;
  assign io.led = led;
  assign io.busy = busy;
  assign io.done = done;
  assign run = st == GET_N || st == GET_X || st == GET_OP;
  assign tick = run && cnt == CW'(TICK_DIV - 1);
  assign x = mem[idx];
  assign sq = {8'b0, x} * {8'b0, x};
  assign mm = {8'b0, m} * {8'b0, m};
  // Divider: first step takes its dividend straight from the accumulators.
  assign dsrc = dcnt == 5'd0 ? (st == DIV1 && op == 2'd3 ? sumsq : {8'b0, sum}) : dq;
  assign trial = {dcnt == 5'd0 ? {IW{1'b0}} : rem, dsrc[19]};
  assign ge = trial >= {1'b0, n};
  assign rem_n = ge ? IW'(trial - {1'b0, n}) : trial[IW-1:0];
  assign dq_n = {dsrc[18:0], ge};
  assign last_div = dcnt == 5'd19;
  // Non-restoring root: the sign of the partial remainder picks add or subtract.
  assign sr_sh = {sr[9:0], vs[15:14]};
  assign sr_n = sr[11] ? sr_sh + {2'b0, rt, 2'b11} : sr_sh - {2'b0, rt, 2'b01};
  assign rt_n = {rt[6:0], ~sr_n[11]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE, SHOW: nxt = io.start ? GET_N : st;
      GET_N:      nxt = tick && io.sw != 8'd0 ? GET_X : st;
      GET_X:      nxt = tick && idx == n - IW'(1) ? GET_OP : st;
      GET_OP:     nxt = tick ? ACCUM : st;
      ACCUM:      nxt = idx != n - IW'(1) ? st : op[0] ? DIV1 : FIN;
      DIV1:       nxt = !last_div ? st : op == 2'd1 ? FIN : DIV2;
      DIV2:       nxt = last_div ? VAR : st;
      VAR:        nxt = SQRT;
      SQRT:       nxt = scnt == 3'd7 ? FIN : st;
      FIN:        nxt = SHOW;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (st == GET_X && tick) mem[idx] <= io.sw;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      n <= '0;
      idx <= '0;
      rem <= '0;
      op <= '0;
      sum <= '0;
      sumsq <= '0;
      dq <= '0;
      dcnt <= '0;
      q1 <= '0;
      m <= '0;
      vs <= '0;
      sr <= '0;
      rt <= '0;
      scnt <= '0;
      res <= '0;
      led <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt <= run && !tick ? cnt + CW'(1) : '0;
      case (st)
        IDLE, SHOW: if (io.start) begin
          led <= '0;
          busy <= 1'b1;
        end
        GET_N: if (tick) begin
          led <= io.sw;
          n <= io.sw > 8'(MAX_N) ? IW'(MAX_N) : io.sw[IW-1:0];
          idx <= '0;
        end
        GET_X: if (tick) begin
          led <= io.sw;
          idx <= idx + IW'(1);
        end
        GET_OP: if (tick) begin
          op <= io.sw > 8'd2 ? 2'd3 : io.sw[1:0];
          idx <= '0;
          sum <= '0;
          sumsq <= '0;
        end
        ACCUM: begin
          sum <= sum + {4'b0, x};
          sumsq <= sumsq + {4'b0, sq};
          idx <= idx + IW'(1);
          dcnt <= '0;
        end
        DIV1, DIV2: begin
          dq <= dq_n;
          rem <= rem_n;
          dcnt <= last_div ? 5'd0 : dcnt + 5'd1;
          if (last_div && st == DIV1) begin
            res <= dq_n[7:0];
            q1 <= dq_n[15:0];
          end
          if (last_div && st == DIV2) m <= dq_n[7:0];
        end
        VAR: begin
          vs <= q1 - mm;
          sr <= '0;
          rt <= '0;
          scnt <= '0;
        end
        SQRT: begin
          vs <= {vs[13:0], 2'b00};
          sr <= sr_n;
          rt <= rt_n;
          scnt <= scnt + 3'd1;
          if (scnt == 3'd7) res <= rt_n;
        end
        FIN: begin
          led <= op == 2'd0 ? sum[7:0] : op == 2'd2 ? sumsq[7:0] : res;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stats_seq_ctrl.sv
// tb_stats_seq_ctrl: directed sessions with a scoreboard of expected result/done latency.
module tb_stats_seq_ctrl;
  localparam int TICK = 4;
  typedef struct {int led; int off;} exp_t;
  logic clk = 0;
  logic rst_n;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] xs [12];
  exp_t sb [$];
  stats_seq_ctrl_if io ();
  stats_seq_ctrl #(.MAX_N(10), .TICK_DIV(TICK)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int nn, input int op_sw);
    int s, ss, q1, m, v, r, opc;
    exp_t e;
    s = 0;
    ss = 0;
    for (int i = 0; i < nn; i++) begin
      s += int'(xs[i]);
      ss += int'(xs[i]) * int'(xs[i]);
    end
    opc = op_sw > 2 ? 3 : op_sw;
    q1 = ss / nn;
    m = s / nn;
    v = q1 - m * m;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    e.led = opc == 0 ? s % 256 : opc == 1 ? m % 256 : opc == 2 ? ss % 256 : r % 256;
    e.off = nn + (opc == 1 ? 21 : opc == 3 ? 50 : 1);
    return e;
  endfunction
  task automatic session(input int n_sw, input int op_sw, input bit zero_first, input bit glitch, input bit abort);
    int nn, k, t;
    exp_t e;
    nn = n_sw > 10 ? 10 : n_sw;
    @(negedge clk);
    io.start = 1;
    io.sw = 0;
    @(negedge clk);
    io.start = 0;
    chk("start_led", io.led, 0);
    chk("start_busy", io.busy, 1);
    if (zero_first) begin
      repeat (TICK) @(negedge clk);
      chk("n_zero_led", io.led, 0);
      chk("n_zero_busy", io.busy, 1);
    end
    io.sw = 8'(n_sw);
    repeat (TICK) @(negedge clk);
    chk("n_led", io.led, n_sw);
    for (int i = 0; i < nn; i++) begin
      io.sw = xs[i];
      if (glitch && i == 1) begin
        io.start = 1;
        @(negedge clk);
        io.start = 0;
        repeat (TICK - 1) @(negedge clk);
      end else repeat (TICK) @(negedge clk);
      chk("x_led", io.led, xs[i]);
    end
    io.sw = 8'(op_sw);
    repeat (TICK) @(negedge clk);
    t = cyc;
    chk("op_led_hold", io.led, xs[nn-1]);
    sb.push_back(model(nn, op_sw));
    io.sw = 8'hA5;
    if (glitch) begin
      io.start = 1;
      @(negedge clk);
      io.start = 0;
    end
    if (abort) begin
      repeat (nn + 3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("abort_led", io.led, 0);
      chk("abort_busy", io.busy, 0);
      chk("abort_done", io.done, 0);
      void'(sb.pop_front());
      @(negedge clk);
      rst_n = 1;
      return;
    end
    k = 0;
    while (!io.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", io.done, 1);
    e = sb.pop_front();
    chk("result_led", io.led, e.led);
    chk("done_cycle", cyc - t, e.off);
    chk("busy_low", io.busy, 0);
    @(negedge clk);
    chk("done_pulse", io.done, 0);
    chk("show_hold", io.led, e.led);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0;
    io.start = 0;
    io.sw = 0;
    repeat (2) @(negedge clk);
    chk("rst_led", io.led, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    rst_n = 1;
    xs = '{2, 4, 4, 4, 5, 5, 7, 9, 0, 0, 0, 0};
    session(8, 0, 0, 0, 0);
    session(8, 1, 0, 1, 0);
    session(8, 2, 0, 0, 0);
    session(8, 3, 0, 0, 0);
    foreach (xs[i]) xs[i] = 8'd255;
    for (int o = 0; o < 4; o++) session(10, o, 0, 0, 0);
    foreach (xs[i]) xs[i] = 8'(i + 1);
    session(12, 0, 1, 0, 0);
    xs = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    session(2, 7, 0, 0, 0);
    xs = '{2, 4, 4, 4, 5, 5, 7, 9, 0, 0, 0, 0};
    session(8, 1, 0, 0, 1);
    chk("post_rst_led", io.led, 0);
    chk("post_rst_busy", io.busy, 0);
    xs[0] = 8'd9;
    session(1, 0, 0, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
